// File: rtl/code_seq_checker_if.sv
// Bus between the upstream state-code source and the code_seq_checker monitor.
// Master drives the code stream; slave (the checker) returns lock/error/wrap status.
interface code_seq_checker_if #(
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 8
);
  logic [W-1:0]     in_code;
  logic             in_valid;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] wrap_cnt;
  logic [W-1:0]     exp_code;

  modport master (
    output in_code, in_valid,
    input  locked, err_pulse, err_cnt, wrap_cnt, exp_code
  );

  modport slave (
    input  in_code, in_valid,
    output locked, err_pulse, err_cnt, wrap_cnt, exp_code
  );
endinterface

// File: rtl/code_seq_checker.sv
// Monitors a cyclic state-code stream (0,1,..,2^W-1,0,..): locks on, counts violations and wraps.
// Optional macro DWELL_CHECK_EN adds a stall check (MAX_DWELL repeats while locked is a violation).
module code_seq_checker #(
  parameter int unsigned W         = 3,
  parameter int unsigned LOCK_N    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_DWELL = 8
) (
  input  logic               clk,
  input  logic               rst,
  code_seq_checker_if.slave  bus
);

  localparam int unsigned MATCH_W = $clog2(LOCK_N + 1);
  localparam logic [W-1:0]     CODE_MAX = {W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Reject out-of-range configurations at elaboration time
  if (LOCK_N < 1 || LOCK_N > 15 || MAX_DWELL < 2 || MAX_DWELL > 255) begin : g_param_err
    $error("code_seq_checker: LOCK_N must be 1..15 and MAX_DWELL 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e             state_q,   state_d;
  logic [W-1:0]       last_q,    last_d;
  logic [W-1:0]       exp_q,     exp_d;
  logic [MATCH_W-1:0] match_q,   match_d;
  logic               locked_q,  locked_d;
  logic               err_q,     err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   wrap_q,    wrap_d;

`ifdef DWELL_CHECK_EN
  localparam int unsigned DWELL_W = 8;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
`endif

  logic [W-1:0] nxt_c;
  logic         hold_c;
  logic         adv_c;

  assign nxt_c  = last_q + W'(1);
  assign hold_c = (bus.in_code == last_q);
  assign adv_c  = (bus.in_code == nxt_c);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Next-state and output decode; only qualified samples move anything
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    match_d   = match_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    wrap_d    = wrap_q;
`ifdef DWELL_CHECK_EN
    dwell_d   = dwell_q;
`endif

    if (bus.in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          last_d  = bus.in_code;
          match_d = '0;
          state_d = ST_HUNT;
        end

        ST_HUNT: begin
          if (adv_c) begin
            last_d  = bus.in_code;
            match_d = match_q + MATCH_W'(1);
            if (match_q == MATCH_W'(LOCK_N - 1)) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
`ifdef DWELL_CHECK_EN
              dwell_d  = '0;
`endif
            end
          end else if (!hold_c) begin
            // Resynchronise silently: hunting never reports errors
            last_d  = bus.in_code;
            match_d = '0;
          end
        end

        ST_LOCK: begin
          if (adv_c) begin
            last_d = bus.in_code;
`ifdef DWELL_CHECK_EN
            dwell_d = '0;
`endif
            if (last_q == CODE_MAX) begin
              wrap_d = sat_inc(wrap_q);
            end
          end else if (hold_c) begin
`ifdef DWELL_CHECK_EN
            dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + DWELL_W'(1);
            // Stalled too long: drop lock but keep last so a resumed count re-locks
            if (dwell_d == DWELL_W'(MAX_DWELL)) begin
              err_d     = 1'b1;
              err_cnt_d = sat_inc(err_cnt_q);
              match_d   = '0;
              dwell_d   = '0;
              locked_d  = 1'b0;
              state_d   = ST_HUNT;
            end
`endif
          end else begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            last_d    = bus.in_code;
            match_d   = '0;
            locked_d  = 1'b0;
            state_d   = ST_HUNT;
`ifdef DWELL_CHECK_EN
            dwell_d   = '0;
`endif
          end
        end

        default: begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
        end
      endcase
    end

    exp_d = last_d + W'(1);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_q    <= '0;
      exp_q     <= W'(1);
      match_q   <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      wrap_q    <= '0;
`ifdef DWELL_CHECK_EN
      dwell_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      wrap_q    <= wrap_d;
`ifdef DWELL_CHECK_EN
      dwell_q   <= dwell_d;
`endif
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.wrap_cnt  = wrap_q;
  assign bus.exp_code  = exp_q;

endmodule

// File: tb/tb_code_seq_checker.sv
// Directed bench for code_seq_checker (W=3, LOCK_N=4, CNT_W=8, MAX_DWELL=8).
// Stall expectations follow DWELL_CHECK_EN so the bench matches either build.
module tb_code_seq_checker;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [2:0] m_last;
  logic [2:0] bad;
  logic [7:0] m_err;
  logic [7:0] m_wrap;
  logic       exp_pulse;

  code_seq_checker_if #(.W(3), .CNT_W(8)) bus ();

  code_seq_checker #(
    .W(3), .LOCK_N(4), .CNT_W(8), .MAX_DWELL(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] code);
    @(negedge clk);
    bus.in_code  = code;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_idle(input logic [2:0] code);
    @(negedge clk);
    bus.in_code  = code;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.in_code  = 3'd0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_locked",  32'(bus.locked),    32'd0);
    check_eq("rst_pulse",   32'(bus.err_pulse), 32'd0);
    check_eq("rst_errcnt",  32'(bus.err_cnt),   32'd0);
    check_eq("rst_wrapcnt", 32'(bus.wrap_cnt),  32'd0);
    check_eq("rst_exp",     32'(bus.exp_code),  32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Unrelated codes while hunting never count as errors
    send(3'd5);
    check_eq("idle_load_exp", 32'(bus.exp_code), 32'd6);
    send(3'd2);
    send(3'd7);
    send(3'd1);
    check_eq("hunt_errcnt", 32'(bus.err_cnt),   32'd0);
    check_eq("hunt_locked", 32'(bus.locked),    32'd0);
    check_eq("hunt_pulse",  32'(bus.err_pulse), 32'd0);
    check_eq("hunt_exp",    32'(bus.exp_code),  32'd2);
    send_idle(3'd6);
    check_eq("novalid_exp", 32'(bus.exp_code),  32'd2);
    send_idle(3'd2);
    check_eq("novalid_adv_exp", 32'(bus.exp_code), 32'd2);

    // 2 advances match, then 0 is BAD and must clear the match count
    send(3'd2);
    send(3'd0);
    send(3'd1);
    send(3'd2);
    send(3'd2);
    send(3'd3);
    check_eq("prelock_locked", 32'(bus.locked),   32'd0);
    check_eq("prelock_exp",    32'(bus.exp_code), 32'd4);
    send(3'd4);
    check_eq("lock_locked", 32'(bus.locked),   32'd1);
    check_eq("lock_errcnt", 32'(bus.err_cnt),  32'd0);
    check_eq("lock_exp",    32'(bus.exp_code), 32'd5);

    send_idle(3'd0);
    check_eq("lock_novalid_pulse",  32'(bus.err_pulse), 32'd0);
    check_eq("lock_novalid_locked", 32'(bus.locked),    32'd1);

    // Wrap through 7 -> 0 while locked
    send(3'd5);
    send(3'd6);
    send(3'd7);
    check_eq("prewrap_wrapcnt", 32'(bus.wrap_cnt), 32'd0);
    send(3'd0);
    check_eq("wrap_wrapcnt", 32'(bus.wrap_cnt),  32'd1);
    check_eq("wrap_exp",     32'(bus.exp_code),  32'd1);
    check_eq("wrap_pulse",   32'(bus.err_pulse), 32'd0);
    send(3'd1);
    check_eq("postwrap_exp",    32'(bus.exp_code), 32'd2);
    check_eq("postwrap_locked", 32'(bus.locked),   32'd1);
    send(3'd2);
    send(3'd3);

    // Violation in LOCK: one pulse, drop lock, re-lock after 4 ADVs
    send(3'd6);
    check_eq("viol_pulse",  32'(bus.err_pulse), 32'd1);
    check_eq("viol_errcnt", 32'(bus.err_cnt),   32'd1);
    check_eq("viol_locked", 32'(bus.locked),    32'd0);
    check_eq("viol_exp",    32'(bus.exp_code),  32'd7);
    send(3'd7);
    check_eq("viol_pulse_clr", 32'(bus.err_pulse), 32'd0);
    send(3'd0);
    check_eq("hunt_wrap_ignored", 32'(bus.wrap_cnt), 32'd1);
    send(3'd1);
    check_eq("relock_early", 32'(bus.locked), 32'd0);
    send(3'd2);
    check_eq("relock_locked", 32'(bus.locked),  32'd1);
    check_eq("relock_errcnt", 32'(bus.err_cnt), 32'd1);

    // Stall on code 2 for nine samples
    m_err = 8'd1;
    for (int r = 1; r <= 9; r++) begin
      send(3'd2);
`ifdef DWELL_CHECK_EN
      exp_pulse = (r == 8);
      if (r == 8) m_err = m_err + 8'd1;
`else
      exp_pulse = 1'b0;
`endif
      check_eq($sformatf("dwell_pulse_%0d", r), 32'(bus.err_pulse), 32'(exp_pulse));
      if (r == 7) check_eq("dwell_locked_7", 32'(bus.locked), 32'd1);
    end
`ifdef DWELL_CHECK_EN
    check_eq("dwell_locked", 32'(bus.locked), 32'd0);
`else
    check_eq("dwell_locked", 32'(bus.locked), 32'd1);
`endif
    check_eq("dwell_errcnt", 32'(bus.err_cnt), 32'(m_err));

    send(3'd3);
    send(3'd4);
    send(3'd5);
    send(3'd6);
    check_eq("resume_locked", 32'(bus.locked), 32'd1);
    m_last = 3'd6;

    // Lock/violate repeatedly until err_cnt saturates
    for (int i = 0; i < 260; i++) begin
      bad = m_last + 3'd4;
      send(bad);
      m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
      check_eq("sat_pulse",  32'(bus.err_pulse), 32'd1);
      check_eq("sat_errcnt", 32'(bus.err_cnt),   32'(m_err));
      m_last = bad;
      for (int k = 0; k < 4; k++) begin
        m_last = m_last + 3'd1;
        send(m_last);
      end
      check_eq("sat_relock", 32'(bus.locked), 32'd1);
    end
    check_eq("sat_final_errcnt", 32'(bus.err_cnt),  32'd255);
    check_eq("sat_wrapcnt",      32'(bus.wrap_cnt), 32'd1);

    // Run enough wraps to saturate wrap_cnt
    m_wrap = 8'd1;
    for (int i = 0; i < 260 * 8; i++) begin
      if (m_last == 3'd7) m_wrap = (m_wrap == 8'hFF) ? m_wrap : m_wrap + 8'd1;
      m_last = m_last + 3'd1;
      send(m_last);
      if (m_last == 3'd0) check_eq("wrap_sat_cnt", 32'(bus.wrap_cnt), 32'(m_wrap));
    end
    check_eq("wrap_sat_final", 32'(bus.wrap_cnt),  32'd255);
    check_eq("wrap_sat_lock",  32'(bus.locked),    32'd1);
    check_eq("wrap_sat_err",   32'(bus.err_cnt),   32'd255);
    check_eq("wrap_sat_exp",   32'(bus.exp_code),  32'(m_last + 3'd1));

    // Asynchronous reset between edges, with in_valid still high
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_locked",  32'(bus.locked),    32'd0);
    check_eq("arst_pulse",   32'(bus.err_pulse), 32'd0);
    check_eq("arst_errcnt",  32'(bus.err_cnt),   32'd0);
    check_eq("arst_wrapcnt", 32'(bus.wrap_cnt),  32'd0);
    check_eq("arst_exp",     32'(bus.exp_code),  32'd1);
    @(posedge clk);
    #1;
    check_eq("arst_hold_exp", 32'(bus.exp_code), 32'd1);

    // First edge after release captures a valid sample
    @(negedge clk);
    rst = 1'b1;
    bus.in_code  = 3'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_exp",    32'(bus.exp_code), 32'd4);
    check_eq("post_rst_locked", 32'(bus.locked),   32'd0);
    check_eq("post_rst_errcnt", 32'(bus.err_cnt),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
